// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a stallable req/ack handshake
// and registers the result into the MEM/WB payload.
module mem_access_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic                  WB_i,
  input  logic                  WBSrc_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [ADDR_W-1:0]     ALUres_i,
  input  logic [DATA_W-1:0]     MemWdata_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  valid_o,
  output logic                  WB_o,
  output logic                  WBSrc_o,
  output logic [DATA_W-1:0]     MemRdata_o,
  output logic [ADDR_W-1:0]     ALUres_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  misalign_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  wb_pend_q, wb_pend_d;
  logic                  wbsrc_pend_q, wbsrc_pend_d;
  logic [REG_ADDR_W-1:0] rd_pend_q, rd_pend_d;
  logic                  valid_q, valid_d;
  logic                  wb_q, wb_d;
  logic                  wbsrc_q, wbsrc_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [ADDR_W-1:0]     alures_q, alures_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  misalign_q, misalign_d;
  logic                  memop_c;
  logic                  aligned_c;
  logic                  stall_c;

  // State register and all registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wb_pend_q    <= 1'b0;
      wbsrc_pend_q <= 1'b0;
      rd_pend_q    <= '0;
      valid_q      <= 1'b0;
      wb_q         <= 1'b0;
      wbsrc_q      <= 1'b0;
      rdata_q      <= '0;
      alures_q     <= '0;
      rd_q         <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_pend_q    <= wb_pend_d;
      wbsrc_pend_q <= wbsrc_pend_d;
      rd_pend_q    <= rd_pend_d;
      valid_q      <= valid_d;
      wb_q         <= wb_d;
      wbsrc_q      <= wbsrc_d;
      rdata_q      <= rdata_d;
      alures_q     <= alures_d;
      rd_q         <= rd_d;
      misalign_q   <= misalign_d;
    end
  end

  // Next-state, memory request and MEM/WB payload
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wb_pend_d    = wb_pend_q;
    wbsrc_pend_d = wbsrc_pend_q;
    rd_pend_d    = rd_pend_q;
    valid_d      = 1'b0;
    wb_d         = wb_q;
    wbsrc_d      = wbsrc_q;
    rdata_d      = rdata_q;
    alures_d     = alures_q;
    rd_d         = rd_q;
    misalign_d   = 1'b0;
    stall_c      = 1'b0;
    memop_c      = valid_i & (MemRead_i | MemWrite_i);
    aligned_c    = (ALUres_i[1:0] == 2'b00);

    case (state_q)
      IDLE: begin
        if (!valid_i) begin
          wb_d = 1'b0;
        end else if (!memop_c || !aligned_c) begin
          // ALU op passes through; a misaligned memory op retires without access
          valid_d    = 1'b1;
          wb_d       = memop_c ? 1'b0 : WB_i;
          misalign_d = memop_c;
          wbsrc_d    = WBSrc_i;
          alures_d   = ALUres_i;
          rd_d       = rd_addr_i;
          rdata_d    = '0;
        end else begin
          stall_c      = 1'b1;
          state_d      = ACCESS;
          mem_req_d    = 1'b1;
          mem_we_d     = MemWrite_i;
          mem_addr_d   = {ALUres_i[ADDR_W-1:2], 2'b00};
          mem_wdata_d  = MemWdata_i;
          wb_pend_d    = WB_i;
          wbsrc_pend_d = WBSrc_i;
          rd_pend_d    = rd_addr_i;
        end
      end
      ACCESS: begin
        stall_c = ~mem_ack_i;
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
          wb_d      = mem_we_q ? 1'b0 : wb_pend_q;
          wbsrc_d   = wbsrc_pend_q;
          alures_d  = mem_addr_q;
          rd_d      = rd_pend_q;
          rdata_d   = mem_we_q ? '0 : mem_rdata_i;
        end
      end
    endcase
  end

  // Stall is gated by reset so it drops the moment reset asserts
  assign stall_o     = rst_n_i & stall_c;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign valid_o     = valid_q;
  assign WB_o        = wb_q;
  assign WBSrc_o     = wbsrc_q;
  assign MemRdata_o  = rdata_q;
  assign ALUres_o    = alures_q;
  assign rd_addr_o   = rd_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a random
// instruction stream checked against a transaction-level memory model.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_i, wb_i, wbsrc_i, mrd_i, mwr_i;
  logic [31:0] alures_i, wdata_i;
  logic [4:0]  rd_i;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        valid_o, wb_o, wbsrc_o, misalign_o;
  logic [31:0] rdata_o, alures_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] dev_mem [int];

  mem_access_stage dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .valid_i(valid_i), .WB_i(wb_i), .WBSrc_i(wbsrc_i),
    .MemRead_i(mrd_i), .MemWrite_i(mwr_i),
    .ALUres_i(alures_i), .MemWdata_i(wdata_i), .rd_addr_i(rd_i),
    .stall_o(stall), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .valid_o(valid_o), .WB_o(wb_o), .WBSrc_o(wbsrc_o),
    .MemRdata_o(rdata_o), .ALUres_o(alures_o), .rd_addr_o(rd_o),
    .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // Presents one instruction starting just after a rising edge, plays the
  // memory with `waits` wait cycles, and checks the retired result.
  task automatic issue(input bit v, input bit wb, input bit wbsrc, input bit rd_en,
                       input bit wr_en, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input int waits);
    bit memop, mis, is_store, exp_wb, done;
    logic [31:0] exp_rdata;
    int exp_stall, stall_cnt, req_cnt;
    memop    = v && (rd_en || wr_en);
    mis      = memop && (addr[1:0] != 2'b00);
    is_store = memop && wr_en;
    exp_wb   = v && wb && !mis && !is_store;
    exp_rdata = 32'h0;
    if (memop && !mis && !is_store)
      exp_rdata = ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : 32'h0;
    if (is_store && !mis) ref_mem[int'(addr >> 2)] = wdata;
    exp_stall = (memop && !mis) ? waits + 1 : 0;

    valid_i = v; wb_i = wb; wbsrc_i = wbsrc; mrd_i = rd_en; mwr_i = wr_en;
    alures_i = addr; wdata_i = wdata; rd_i = rd;
    stall_cnt = 0; req_cnt = 0; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        checks++;
        if ({mem_we, mem_addr} !== {is_store, addr[31:2], 2'b00} ||
            (is_store && mem_wdata !== wdata)) begin
          errors++;
          $display("FAIL mem_bus: got we=%0b addr=%h wdata=%h expected we=%0b addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, is_store, {addr[31:2], 2'b00}, wdata);
        end
        if (req_cnt == waits) begin
          mem_ack = 1'b1;
          if (mem_we) dev_mem[int'(mem_addr >> 2)] = mem_wdata;
          else mem_rdata = dev_mem.exists(int'(mem_addr >> 2)) ? dev_mem[int'(mem_addr >> 2)] : 32'h0;
        end
        req_cnt++;
      end
      #1;
      if (stall) stall_cnt++;
      done = !stall;
      @(posedge clk); #1;
      if (!done) begin
        checks++;
        if (valid_o !== 1'b0) begin
          errors++;
          $display("FAIL early_valid: got valid_o=%0b expected 0 while stalled", valid_o);
        end
      end
    end
    mem_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stall still %0b after 30 cycles expected 0", stall);
    end
    checks++;
    if (stall_cnt != exp_stall || req_cnt != (exp_stall)) begin
      errors++;
      $display("FAIL stall_req_cycles: got stall=%0d req=%0d expected %0d/%0d",
               stall_cnt, req_cnt, exp_stall, exp_stall);
    end
    checks++;
    if ({valid_o, wb_o, misalign_o} !== {v, exp_wb, mis}) begin
      errors++;
      $display("FAIL ctrl_out: got valid=%0b wb=%0b mis=%0b expected %0b %0b %0b",
               valid_o, wb_o, misalign_o, v, exp_wb, mis);
    end
    if (v && !mis) begin
      checks++;
      if ({wbsrc_o, rd_o, alures_o, rdata_o} !== {wbsrc, rd, addr, exp_rdata}) begin
        errors++;
        $display("FAIL data_out: got wbsrc=%0b rd=%0d alu=%h rdata=%h expected %0b %0d %h %h",
                 wbsrc_o, rd_o, alures_o, rdata_o, wbsrc, rd, addr, exp_rdata);
      end
    end
  endtask

  task automatic idle_inputs();
    valid_i = 0; wb_i = 0; wbsrc_i = 0; mrd_i = 0; mwr_i = 0;
    alures_i = 0; wdata_i = 0; rd_i = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({stall, mem_req, mem_we, mem_addr, mem_wdata, valid_o, wb_o, wbsrc_o,
         rdata_o, alures_o, rd_o, misalign_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: got req=%0b valid=%0b addr=%h rdata=%h expected all zero",
               mem_req, valid_o, mem_addr, rdata_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_op();
    issue(1, 1, 0, 0, 0, 32'h1234, 32'h0, 5'd5, 0);
    issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
  endtask

  task automatic test_load_zero_wait();
    ref_mem[int'(32'h100 >> 2)] = 32'hDEADBEEF;
    dev_mem[int'(32'h100 >> 2)] = 32'hDEADBEEF;
    issue(1, 1, 1, 1, 0, 32'h100, 32'h0, 5'd7, 0);
    checks++;
    if (rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_data: got %h expected DEADBEEF", rdata_o);
    end
  endtask

  task automatic test_store_wait3();
    issue(1, 1, 0, 0, 1, 32'h200, 32'hA5A5A5A5, 5'd9, 3);
    issue(1, 1, 1, 1, 0, 32'h200, 32'h0, 5'd10, 1);
  endtask

  task automatic test_misaligned();
    issue(1, 1, 1, 1, 0, 32'h102, 32'h0, 5'd3, 0);
    issue(1, 1, 0, 1, 1, 32'h201, 32'h55, 5'd3, 0);
    issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
    checks++;
    if (misalign_o !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: got %0b expected 0 on following cycle", misalign_o);
    end
  endtask

  task automatic test_reset_mid_access();
    valid_i = 1; wb_i = 0; wbsrc_i = 0; mrd_i = 0; mwr_i = 1;
    alures_i = 32'h40; wdata_i = 32'h12345678; rd_i = 5'd1;
    @(posedge clk); #1;
    checks++;
    if ({mem_req, stall} !== 2'b11) begin
      errors++;
      $display("FAIL access_entry: got req=%0b stall=%0b expected 1 1", mem_req, stall);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, stall, valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got req=%0b stall=%0b valid=%0b expected 0 0 0",
               mem_req, stall, valid_o);
    end
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 1, 0, 0, 0, 32'hCAFE0000, 32'h0, 5'd2, 0);
    issue(1, 1, 1, 1, 0, 32'h40, 32'h0, 5'd4, 0);
  endtask

  task automatic test_back_to_back();
    int t0;
    int t_ld, t_st, t_alu;
    ref_mem[int'(32'h300 >> 2)] = 32'h0BADF00D;
    dev_mem[int'(32'h300 >> 2)] = 32'h0BADF00D;
    t0 = cyc_cnt;
    issue(1, 1, 1, 1, 0, 32'h300, 32'h0, 5'd11, 1);
    t_ld = cyc_cnt - t0;
    issue(1, 0, 0, 0, 1, 32'h304, 32'h13572468, 5'd12, 1);
    t_st = cyc_cnt - t0;
    issue(1, 1, 0, 0, 0, 32'h77, 32'h0, 5'd13, 1);
    t_alu = cyc_cnt - t0;
    checks++;
    if (t_ld != 3 || t_st != 6 || t_alu != 7) begin
      errors++;
      $display("FAIL b2b_timing: got cycles %0d,%0d,%0d expected 3,6,7", t_ld, t_st, t_alu);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [31:0] addr;
      bit rd_en, wr_en, v;
      kind = int'($urandom_range(0, 9));
      addr = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
      v = (kind != 0);
      rd_en = 0; wr_en = 0;
      if (kind >= 4 && kind <= 6) rd_en = 1;
      if (kind == 7 || kind == 8) begin
        wr_en = 1;
        rd_en = 1'($urandom_range(0, 1));
      end
      if (kind == 9) begin
        rd_en = 1;
        addr[1:0] = 2'($urandom_range(1, 3));
      end
      if (kind >= 1 && kind <= 3) addr = $urandom;
      issue(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd_en, wr_en,
            addr, $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_zero_wait();
    test_store_wait3();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
